dds_amp_scale: RTL and testbench

DDS_AMP_SCALE -- requirements
Module: dds_amp_scale

---
 rtl/dds_amp_scale.sv | 108 ++++++++++
 tb/tb_dds_amp_scale.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dds_amp_scale.sv
// dds_amp_scale: applies an 8-bit amplitude gain to an offset-binary DDS sample stream.
// The gain changes only at waveform period boundaries. Define AMP_RAMP_EN to step the gain by RAMP_STEP per period.
`default_nettype none

module dds_amp_scale #(
    parameter int RAMP_STEP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_ver,
    input  logic [7:0] wave_dat,
    input  logic       wave_vld,
    input  logic       phase_wrap,
    output logic [7:0] dac_dat,
    output logic       dac_vld,
    output logic [7:0] gain_cur,
    output logic       gain_pend
);

    if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_param_check
        $error("RAMP_STEP must be in 1..255");
    end

    logic [7:0]        tgt;
    logic [7:0]        gain_next;
    logic              wrap_q;
    logic [7:0]        gain_sel;
    logic signed [8:0] s_in;
    logic signed [8:0] s1;
    logic [7:0]        g1;
    logic              v1;
    logic signed [17:0] prod;
    logic signed [9:0]  y;
    logic [7:0]        y_clamp;

    assign wrap_q = wave_vld & phase_wrap;

`ifdef AMP_RAMP_EN
    localparam logic [7:0] STEP = 8'(RAMP_STEP);

    // Bounded step toward the target; the step never passes tgt, so it cannot wrap.
    always_comb begin
        gain_next = gain_cur;
        if (tgt > gain_cur) begin
            if ((tgt - gain_cur) > STEP) gain_next = gain_cur + STEP;
            else                         gain_next = tgt;
        end else if (tgt < gain_cur) begin
            if ((gain_cur - tgt) > STEP) gain_next = gain_cur - STEP;
            else                         gain_next = tgt;
        end
    end
`else
    assign gain_next = tgt;
`endif

    // The wrap sample itself takes the new gain.
    assign gain_sel = wrap_q ? gain_next : gain_cur;
    assign s_in     = 9'($signed({1'b0, wave_dat}) - 9'sd128);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt       <= 8'd0;
            gain_cur  <= 8'd0;
            gain_pend <= 1'b0;
        end else begin
            tgt       <= a_ver;
            gain_pend <= (tgt != gain_cur);
            if (wrap_q) gain_cur <= gain_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 9'sd0;
            g1 <= 8'd0;
            v1 <= 1'b0;
        end else begin
            v1 <= wave_vld;
            if (wave_vld) begin
                s1 <= s_in;
                g1 <= gain_sel;
            end
        end
    end

    // Product of +/-128 by 0..255 stays within 18 bits; floor shift keeps the result within 10 bits.
    assign prod = s1 * $signed({1'b0, g1});
    assign y    = 10'sd128 + $signed(prod[17:8]);

    always_comb begin
        y_clamp = y[7:0];
        if (y < 10'sd0)        y_clamp = 8'd0;
        else if (y > 10'sd255) y_clamp = 8'd255;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_dat <= 8'd128;
            dac_vld <= 1'b0;
        end else begin
            dac_vld <= v1;
            if (v1) dac_dat <= y_clamp;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dds_amp_scale.sv
// tb_dds_amp_scale: directed self-checking bench for dds_amp_scale with hand-computed expected values.
`default_nettype none

module tb_dds_amp_scale;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_ver = 8'd0;
    logic [7:0] wave_dat = 8'd128;
    logic       wave_vld = 1'b0;
    logic       phase_wrap = 1'b0;
    logic [7:0] dac_dat;
    logic       dac_vld;
    logic [7:0] gain_cur;
    logic       gain_pend;

    int errors = 0;
    int checks = 0;

    dds_amp_scale #(.RAMP_STEP(8)) dut (
        .clk(clk), .rst(rst), .a_ver(a_ver), .wave_dat(wave_dat),
        .wave_vld(wave_vld), .phase_wrap(phase_wrap), .dac_dat(dac_dat),
        .dac_vld(dac_vld), .gain_cur(gain_cur), .gain_pend(gain_pend)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic wrap, input logic [7:0] dat);
        wave_vld   = vld;
        phase_wrap = wrap;
        wave_dat   = dat;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (dac_dat !== 8'd128) begin errors++; $display("FAIL reset_dat: got %0d want 128", dac_dat); end
        checks++; if (dac_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b want 0", dac_vld); end
        checks++; if (gain_cur !== 8'd0) begin errors++; $display("FAIL reset_gain: got %0d want 0", gain_cur); end
        checks++; if (gain_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %0b want 0", gain_pend); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency_math();
        a_ver = 8'd255;
        tick();
        drive(1'b1, 1'b1, 8'd255);
        tick();
        checks++; if (dac_vld !== 1'b0) begin errors++; $display("FAIL lat_early: got %0b want 0", dac_vld); end
        drive(1'b1, 1'b0, 8'd0);
        tick();
        checks++; if (dac_vld !== 1'b1 || dac_dat !== 8'd254) begin errors++; $display("FAIL lat_255: got vld=%0b dat=%0d want 1/254", dac_vld, dac_dat); end
        checks++; if (gain_cur !== 8'd255) begin errors++; $display("FAIL lat_gain: got %0d want 255", gain_cur); end
        drive(1'b1, 1'b0, 8'd128);
        tick();
        checks++; if (dac_vld !== 1'b1 || dac_dat !== 8'd0) begin errors++; $display("FAIL lat_0: got vld=%0b dat=%0d want 1/0", dac_vld, dac_dat); end
        drive(1'b0, 1'b0, 8'd128);
        tick();
        checks++; if (dac_vld !== 1'b1 || dac_dat !== 8'd128) begin errors++; $display("FAIL lat_128: got vld=%0b dat=%0d want 1/128", dac_vld, dac_dat); end
        tick();
        checks++; if (dac_vld !== 1'b0) begin errors++; $display("FAIL lat_tail: got %0b want 0", dac_vld); end
    endtask

    task automatic test_gain_half();
        a_ver = 8'd128;
        tick();
        drive(1'b1, 1'b1, 8'd200);
        tick();
        drive(1'b1, 1'b0, 8'd56);
        tick();
        checks++; if (dac_vld !== 1'b1 || dac_dat !== 8'd164) begin errors++; $display("FAIL half_200: got vld=%0b dat=%0d want 1/164", dac_vld, dac_dat); end
        drive(1'b0, 1'b0, 8'd0);
        tick();
        checks++; if (dac_vld !== 1'b1 || dac_dat !== 8'd92) begin errors++; $display("FAIL half_56: got vld=%0b dat=%0d want 1/92", dac_vld, dac_dat); end
        tick();
        tick();
        checks++; if (dac_vld !== 1'b0 || dac_dat !== 8'd92) begin errors++; $display("FAIL hold: got vld=%0b dat=%0d want 0/92", dac_vld, dac_dat); end
        checks++; if (gain_pend !== 1'b0) begin errors++; $display("FAIL half_pend: got %0b want 0", gain_pend); end
    endtask

    task automatic test_reset_midstream();
        a_ver = 8'd0;
        drive(1'b1, 1'b0, 8'd255);
        tick();
        drive(1'b1, 1'b0, 8'd0);
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (dac_dat !== 8'd128 || dac_vld !== 1'b0 || gain_cur !== 8'd0) begin
            errors++; $display("FAIL rst_mid: got dat=%0d vld=%0b gain=%0d want 128/0/0", dac_dat, dac_vld, gain_cur);
        end
        drive(1'b0, 1'b0, 8'd128);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dac_vld !== 1'b0) begin errors++; $display("FAIL rst_stale%0d: got %0b want 0", i, dac_vld); end
        end
    endtask

    task automatic test_boundary();
        a_ver = 8'd200;
        drive(1'b1, 1'b0, 8'd255);
        tick();
        drive(1'b1, 1'b0, 8'd255);
        tick();
        checks++; if (gain_pend !== 1'b1) begin errors++; $display("FAIL bnd_pend: got %0b want 1", gain_pend); end
        checks++; if (dac_vld !== 1'b1 || dac_dat !== 8'd128) begin errors++; $display("FAIL bnd_old0: got vld=%0b dat=%0d want 1/128", dac_vld, dac_dat); end
        drive(1'b1, 1'b1, 8'd255);
        tick();
        checks++; if (dac_dat !== 8'd128 || gain_cur !== 8'd200) begin errors++; $display("FAIL bnd_old1: got dat=%0d gain=%0d want 128/200", dac_dat, gain_cur); end
        drive(1'b1, 1'b0, 8'd0);
        tick();
        checks++; if (dac_vld !== 1'b1 || dac_dat !== 8'd227) begin errors++; $display("FAIL bnd_wrap: got vld=%0b dat=%0d want 1/227", dac_vld, dac_dat); end
        drive(1'b0, 1'b0, 8'd128);
        tick();
        checks++; if (dac_vld !== 1'b1 || dac_dat !== 8'd28) begin errors++; $display("FAIL bnd_next: got vld=%0b dat=%0d want 1/28", dac_vld, dac_dat); end
        tick();
        checks++; if (gain_pend !== 1'b0) begin errors++; $display("FAIL bnd_pend_clr: got %0b want 0", gain_pend); end
    endtask

    task automatic test_wrap_invalid();
        a_ver = 8'd50;
        tick();
        tick();
        drive(1'b0, 1'b1, 8'd255);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dac_vld !== 1'b0 || gain_cur !== 8'd200) begin
                errors++; $display("FAIL wrap_inv%0d: got vld=%0b gain=%0d want 0/200", i, dac_vld, gain_cur);
            end
        end
        checks++; if (gain_pend !== 1'b1 || dac_dat !== 8'd28) begin errors++; $display("FAIL wrap_inv_hold: got pend=%0b dat=%0d want 1/28", gain_pend, dac_dat); end
        drive(1'b0, 1'b0, 8'd128);
    endtask

    task automatic test_ramp();
        logic [7:0] exp_g [3];
        exp_g[0] = 8'd8; exp_g[1] = 8'd16; exp_g[2] = 8'd20;
        a_ver = 8'd20;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (gain_pend !== 1'b1) begin errors++; $display("FAIL ramp_pend%0d: got %0b want 1", i, gain_pend); end
            drive(1'b1, 1'b1, 8'd128);
            tick();
            drive(1'b0, 1'b0, 8'd128);
            checks++; if (gain_cur !== exp_g[i]) begin errors++; $display("FAIL ramp_gain%0d: got %0d want %0d", i, gain_cur, exp_g[i]); end
            tick();
        end
        tick();
        checks++; if (gain_pend !== 1'b0) begin errors++; $display("FAIL ramp_pend_clr: got %0b want 0", gain_pend); end
    endtask

    initial begin
        test_reset();
`ifdef AMP_RAMP_EN
        test_ramp();
`else
        test_latency_math();
        test_gain_half();
        test_reset_midstream();
        test_boundary();
        test_wrap_invalid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
